// File: rtl/alu_pipe_if.sv
`default_nettype none
// =============================================================================
// alu_pipe_if : valid/ready operand and result bus for alu_pipe   (rev 1.0)
// =============================================================================
interface alu_pipe_if #(
   parameter int WIDTH = 16,
   parameter int SELW  = 4
);
   logic             InValid;
   logic             InReady;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [SELW-1:0]  Sel;
   logic             OutValid;
   logic             OutReady;
   logic [WIDTH-1:0] Q;
   logic [3:0]       Flags;
   logic             Err;

   modport master (
      output InValid, A, B, Sel, OutReady,
      input  InReady, OutValid, Q, Flags, Err
   );

   modport slave (
      input  InValid, A, B, Sel, OutReady,
      output InReady, OutValid, Q, Flags, Err
   );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// =============================================================================
// alu_pipe : 2-stage valid/ready pipelined ALU with {V,C,N,Z} flags   (rev 1.0)
// =============================================================================
module alu_pipe #(
   parameter int WIDTH = 16,
   parameter int N_OP  = 16
) (
   input  logic      Clk,
   input  logic      ResetN,
   alu_pipe_if.slave bus
);
   localparam int SELW = $clog2(N_OP);
   localparam int SHW  = $clog2(WIDTH);
   localparam int MSB  = WIDTH - 1;

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [SELW-1:0]  sel_q;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [3:0]       flags_q, flags_d;
   logic             err_q, err_d;
   logic             s2_en, in_fire;
   logic [3:0]       op;
   logic [SHW-1:0]   sh;
   logic             c, v;

   if (SELW < 4) begin : g_op_ext
      assign op = {{(4 - SELW){1'b0}}, sel_q};
   end else begin : g_op_full
      assign op = sel_q[3:0];
   end

   // Ready is a function of registered state and OutReady only.
   assign s2_en       = !out_valid_q || bus.OutReady;
   assign bus.InReady = !s1_valid_q || s2_en;
   assign in_fire     = bus.InValid && bus.InReady;
   assign s1_valid_d  = in_fire || (s1_valid_q && !s2_en);
   assign out_valid_d = s2_en ? s1_valid_q : out_valid_q;
   assign sh          = b_q[SHW-1:0];

   always_comb begin
      q_d   = '0;
      c     = 1'b0;
      v     = 1'b0;
      err_d = 1'b0;
      case (op)
         4'd0: q_d = '0;
         4'd1: begin
            {c, q_d} = {1'b0, a_q} + {1'b0, b_q};
            v = (a_q[MSB] == b_q[MSB]) && (q_d[MSB] != a_q[MSB]);
         end
         4'd2: begin
            {c, q_d} = {1'b0, a_q} - {1'b0, b_q};
            v = (a_q[MSB] != b_q[MSB]) && (q_d[MSB] != a_q[MSB]);
         end
         4'd3: q_d = a_q;
         4'd4: q_d = a_q ^ b_q;
         4'd5: q_d = a_q | b_q;
         4'd6: q_d = a_q & b_q;
         4'd7: begin
            {c, q_d} = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
            v = !a_q[MSB] && q_d[MSB];
         end
         // The extra guard bit catches the last bit shifted out (0 for sh=0).
         4'd8:  {c, q_d} = {1'b0, a_q} << sh;
         4'd9:  {q_d, c} = {a_q, 1'b0} >> sh;
         4'd10: {q_d, c} = $signed({a_q, 1'b0}) >>> sh;
         4'd11: q_d = {{(WIDTH - 1){1'b0}}, (a_q < b_q)};
         default: err_d = 1'b1;
      endcase
      flags_d = err_d ? 4'b0000 : {v, c, q_d[MSB], (q_d == '0)};
   end

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         s1_valid_q  <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= '0;
         out_valid_q <= 1'b0;
         q_q         <= '0;
         flags_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         if (in_fire) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            sel_q <= bus.Sel;
         end
         if (s2_en && s1_valid_q) begin
            q_q     <= q_d;
            flags_q <= flags_d;
            err_q   <= err_d;
         end
      end
   end

   assign bus.OutValid = out_valid_q;
   assign bus.Q        = q_q;
   assign bus.Flags    = flags_q;
   assign bus.Err      = err_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// =============================================================================
// tb_alu_pipe : vector table, directed pipeline sequences and random scoreboard
// =============================================================================
module tb_alu_pipe;
   typedef struct packed {
      logic [15:0] q;
      logic [3:0]  f;
      logic        e;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  sel;
      logic [15:0] q;
      logic [3:0]  f;
      logic        e;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(16), .SELW(4)) b16 ();
   alu_pipe_if #(.WIDTH(8),  .SELW(3)) b8  ();

   alu_pipe #(.WIDTH(16), .N_OP(16)) dut16 (.Clk(clk), .ResetN(rst_n), .bus(b16));
   alu_pipe #(.WIDTH(8),  .N_OP(8))  dut8  (.Clk(clk), .ResetN(rst_n), .bus(b8));

   int   n_checks = 0;
   int   n_fail   = 0;
   res_t exp16[$];
   res_t exp8[$];

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   // Reference: signed/unsigned integer arithmetic on the mathematical values.
   function automatic res_t model(int w, logic [15:0] a_in, logic [15:0] b_in, logic [3:0] sel);
      int   mask, half, a, b, sa, sb, sh, r, s;
      bit   c, v, err;
      res_t res;
      mask = (1 << w) - 1;
      half = 1 << (w - 1);
      a    = int'(a_in) & mask;
      b    = int'(b_in) & mask;
      sa   = (a >= half) ? a - (1 << w) : a;
      sb   = (b >= half) ? b - (1 << w) : b;
      sh   = b % w;
      r = 0; s = 0; c = 1'b0; v = 1'b0; err = 1'b0;
      case (sel)
         4'd0: r = 0;
         4'd1: begin r = a + b; c = (r > mask); s = sa + sb; v = (s >= half) || (s < -half); end
         4'd2: begin r = a - b; c = (a < b);    s = sa - sb; v = (s >= half) || (s < -half); end
         4'd3: r = a;
         4'd4: r = a ^ b;
         4'd5: r = a | b;
         4'd6: r = a & b;
         4'd7: begin r = a + 1; c = (r > mask); s = sa + 1; v = (s >= half); end
         4'd8: begin
            r = a << sh;
            if (sh != 0) c = ((a >> (w - sh)) & 1) != 0;
         end
         4'd9: begin
            r = a >> sh;
            if (sh != 0) c = ((a >> (sh - 1)) & 1) != 0;
         end
         4'd10: begin
            r = sa >>> sh;
            if (sh != 0) c = ((a >> (sh - 1)) & 1) != 0;
         end
         4'd11: r = (a < b) ? 1 : 0;
         default: err = 1'b1;
      endcase
      r     = r & mask;
      res.q = 16'(r);
      res.e = err;
      res.f = err ? 4'b0000 : {v, c, (r >= half), (r == 0)};
      return res;
   endfunction

   task automatic set_in(int w, logic iv, logic [15:0] a, logic [15:0] b, logic [3:0] s, logic ordy);
      if (w == 16) begin
         b16.InValid = iv; b16.A = a; b16.B = b; b16.Sel = s; b16.OutReady = ordy;
      end else begin
         b8.InValid = iv; b8.A = a[7:0]; b8.B = b[7:0]; b8.Sel = s[2:0]; b8.OutReady = ordy;
      end
   endtask

   task automatic get_out(int w, output logic ov, output logic ir, output res_t r);
      if (w == 16) begin
         ov = b16.OutValid; ir = b16.InReady;
         r.q = b16.Q; r.f = b16.Flags; r.e = b16.Err;
      end else begin
         ov = b8.OutValid; ir = b8.InReady;
         r.q = {8'h00, b8.Q}; r.f = b8.Flags; r.e = b8.Err;
      end
   endtask

   // One clock cycle: drive, sample, score transfers, advance past the next edge.
   task automatic step(int w, logic iv, logic [15:0] a, logic [15:0] b, logic [3:0] s, logic ordy,
                       output logic ov, output logic ir, output res_t got);
      res_t want;
      int   depth;
      set_in(w, iv, a, b, s, ordy);
      #1;
      get_out(w, ov, ir, got);
      if (iv && ir) begin
         if (w == 16) exp16.push_back(model(w, a, b, s));
         else         exp8.push_back(model(w, a, b, s));
      end
      if (ov && ordy) begin
         depth = (w == 16) ? exp16.size() : exp8.size();
         if (depth == 0) begin
            chk($sformatf("unexpected_out_w%0d", w), 32'(ov), 32'(0));
         end else begin
            if (w == 16) want = exp16.pop_front();
            else         want = exp8.pop_front();
            chk($sformatf("result_w%0d", w), 32'(got), 32'(want));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_random(int w, int n_ops);
      int          accepted, cycles, pick;
      logic        ov, ir, iv, ordy;
      res_t        got;
      logic [15:0] a, b;
      logic [3:0]  s;
      accepted = 0;
      cycles   = 0;
      while (accepted < n_ops && cycles < 60000) begin
         iv   = 1'($urandom_range(0, 1));
         ordy = 1'($urandom_range(0, 1));
         a    = 16'($urandom);
         b    = 16'($urandom);
         s    = (w == 16) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
         pick = $urandom_range(0, 9);
         if (pick == 0) a = 16'h0000;
         if (pick == 1) a = 16'hFFFF;
         if (pick == 2) b = a;
         if (pick == 3) a = (w == 16) ? 16'h7FFF : 16'h007F;
         step(w, iv, a, b, s, ordy, ov, ir, got);
         if (iv && ir) accepted++;
         cycles++;
      end
      while (((w == 16) ? exp16.size() : exp8.size()) != 0 && cycles < 60000) begin
         step(w, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1, ov, ir, got);
         cycles++;
      end
      chk($sformatf("random_w%0d_accepted", w), 32'(accepted), 32'(n_ops));
      chk($sformatf("random_w%0d_drained", w),
          32'((w == 16) ? exp16.size() : exp8.size()), 32'(0));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt[22];
      logic        ov, ir;
      res_t        got;
      int          acc;
      logic [15:0] ra, rb;

      vt[0]  = '{16'hFFFF, 16'h0001, 4'd1,  16'h0000, 4'b0101, 1'b0};
      vt[1]  = '{16'h7FFF, 16'hFFFF, 4'd2,  16'h8000, 4'b1110, 1'b0};
      vt[2]  = '{16'h7FFF, 16'h0000, 4'd7,  16'h8000, 4'b1010, 1'b0};
      vt[3]  = '{16'h8001, 16'h0004, 4'd8,  16'h0010, 4'b0000, 1'b0};
      vt[4]  = '{16'h8001, 16'h0004, 4'd10, 16'hF800, 4'b0010, 1'b0};
      vt[5]  = '{16'h8001, 16'h0004, 4'd9,  16'h0800, 4'b0000, 1'b0};
      vt[6]  = '{16'h8001, 16'h0004, 4'd13, 16'h0000, 4'b0000, 1'b1};
      vt[7]  = '{16'h1234, 16'h0F0F, 4'd4,  16'h1D3B, 4'b0000, 1'b0};
      vt[8]  = '{16'h0003, 16'h0005, 4'd11, 16'h0001, 4'b0000, 1'b0};
      vt[9]  = '{16'h8000, 16'h0001, 4'd8,  16'h0000, 4'b0101, 1'b0};
      vt[10] = '{16'h0005, 16'h0005, 4'd2,  16'h0000, 4'b0001, 1'b0};
      vt[11] = '{16'h1234, 16'h5678, 4'd0,  16'h0000, 4'b0001, 1'b0};
      vt[12] = '{16'hFFFF, 16'h0000, 4'd7,  16'h0000, 4'b0101, 1'b0};
      vt[13] = '{16'h0001, 16'h0000, 4'd12, 16'h0000, 4'b0000, 1'b1};
      vt[14] = '{16'hF0F0, 16'hFF00, 4'd6,  16'hF000, 4'b0010, 1'b0};
      vt[15] = '{16'h8001, 16'h0011, 4'd10, 16'hC000, 4'b0110, 1'b0};
      vt[16] = '{16'h8001, 16'h0010, 4'd8,  16'h8001, 4'b0010, 1'b0};
      vt[17] = '{16'h7FFF, 16'h0001, 4'd1,  16'h8000, 4'b1010, 1'b0};
      vt[18] = '{16'h0001, 16'h0002, 4'd2,  16'hFFFF, 4'b0110, 1'b0};
      vt[19] = '{16'h00F0, 16'h000F, 4'd5,  16'h00FF, 4'b0000, 1'b0};
      vt[20] = '{16'h8001, 16'h0004, 4'd3,  16'h8001, 4'b0010, 1'b0};
      vt[21] = '{16'h8001, 16'h000F, 4'd9,  16'h0001, 4'b0000, 1'b0};

      // Reset state
      rst_n = 1'b0;
      set_in(16, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
      set_in(8,  1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
      #12;
      get_out(16, ov, ir, got);
      chk("reset_outvalid", 32'(ov), 32'(0));
      chk("reset_q_flags_err", 32'(got), 32'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      get_out(16, ov, ir, got);
      chk("post_reset_inready_w16", 32'(ir), 32'(1));
      get_out(8, ov, ir, got);
      chk("post_reset_inready_w8", 32'(ir), 32'(1));

      // Single ops from the table, two-cycle latency
      foreach (vt[i]) begin
         set_in(16, 1'b1, vt[i].a, vt[i].b, vt[i].sel, 1'b1);
         @(posedge clk);
         #1;
         set_in(16, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
         get_out(16, ov, ir, got);
         chk($sformatf("vec%0d_not_early", i), 32'(ov), 32'(0));
         @(posedge clk);
         #1;
         get_out(16, ov, ir, got);
         chk($sformatf("vec%0d_outvalid", i), 32'(ov), 32'(1));
         chk($sformatf("vec%0d_q_flags_err", i), 32'(got), 32'({vt[i].q, vt[i].f, vt[i].e}));
         @(posedge clk);
         #1;
      end

      // Back-to-back ops: eight results on consecutive cycles
      for (int i = 0; i < 11; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         step(16, (i < 8), ra, rb, 4'(i), 1'b1, ov, ir, got);
         if (i < 8) chk($sformatf("b2b_inready_%0d", i), 32'(ir), 32'(1));
         if (i >= 2 && i <= 9) chk($sformatf("b2b_no_gap_%0d", i), 32'(ov), 32'(1));
         if (i == 10) chk("b2b_idle_after", 32'(ov), 32'(0));
      end

      // Backpressure: two ops fill the pipe, then everything holds
      acc = 0;
      for (int j = 0; j < 7; j++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         step(16, 1'b1, ra, rb, 4'($urandom_range(0, 11)), 1'b0, ov, ir, got);
         if (ir) acc++;
         if (j >= 2) begin
            chk($sformatf("stall_inready_%0d", j), 32'(ir), 32'(0));
            chk($sformatf("stall_hold_%0d", j), 32'(got), 32'(exp16[0]));
         end
      end
      chk("stall_accepted", 32'(acc), 32'(2));
      for (int j = 0; j < 4; j++) step(16, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1, ov, ir, got);
      chk("stall_no_loss", 32'(exp16.size()), 32'(0));

      // Random traffic on both configurations in parallel
      fork
         run_random(16, 10000);
         run_random(8, 10000);
      join

      // Reset with both stages occupied
      step(16, 1'b1, 16'h1111, 16'h2222, 4'd1, 1'b0, ov, ir, got);
      step(16, 1'b1, 16'h3333, 16'h4444, 4'd2, 1'b0, ov, ir, got);
      get_out(16, ov, ir, got);
      chk("full_before_reset", 32'(ov), 32'(1));
      rst_n = 1'b0;
      #1;
      get_out(16, ov, ir, got);
      chk("async_reset_outvalid", 32'(ov), 32'(0));
      chk("async_reset_q_flags_err", 32'(got), 32'(0));
      exp16.delete();
      exp8.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         step(16, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1, ov, ir, got);
         chk($sformatf("no_stale_%0d", j), 32'(ov), 32'(0));
      end
      step(16, 1'b1, 16'h00FF, 16'h0001, 4'd1, 1'b1, ov, ir, got);
      for (int j = 0; j < 3; j++) step(16, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1, ov, ir, got);
      chk("recover_after_reset", 32'(exp16.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
